// File: rtl/patch_stim_gen.sv
// Patch-stream stimulus generator: emits 0..N_PATCH-1 once each, sequential, shuffled or reversed per window.
// Optional PATCH_STIM_CHECKSUM_EN adds a 32-bit running sum of accepted patch numbers.
module patch_stim_gen #(
    parameter int N_PATCH          = 600000,
    parameter int SYNC_WINDOW_LOG2 = 13,
    parameter int FP_SIZE          = 20,
    localparam int PN_W            = $clog2(N_PATCH)
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                start,
    input  logic [1:0]          mode,
    output logic                out_val,
    input  logic                out_rdy,
    output logic [PN_W-1:0]     patch_num,
    output logic [FP_SIZE-1:0]  payload,
    output logic                busy,
    output logic                done
`ifdef PATCH_STIM_CHECKSUM_EN
    ,
    output logic [31:0]         checksum
`endif
);

    localparam int K = SYNC_WINDOW_LOG2;
    localparam logic [PN_W:0]   N_VAL    = (PN_W+1)'(N_PATCH);
    localparam logic [PN_W:0]   LAST_IDX = (PN_W+1)'(N_PATCH - 1);
    localparam logic [PN_W-1:0] WIN_STEP = PN_W'(2 ** K);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN} state_t;

    // XNOR feedback taps, bit n-1 set for 1-indexed tap n
    function automatic logic [K-1:0] tap_mask();
        case (K)
            4:       return K'(16'h000C);
            5:       return K'(16'h0014);
            6:       return K'(16'h0030);
            7:       return K'(16'h0060);
            8:       return K'(16'h00B8);
            9:       return K'(16'h0110);
            10:      return K'(16'h0240);
            11:      return K'(16'h0500);
            12:      return K'(16'h0829);
            13:      return K'(16'h100D);
            14:      return K'(16'h2015);
            15:      return K'(16'h6000);
            default: return K'(16'hD008);
        endcase
    endfunction

    localparam logic [K-1:0] TAPS = tap_mask();

    state_t              r_state, w_state_next;
    logic [1:0]          r_mode;
    logic [K-1:0]        r_off, r_lfsr;
    logic [PN_W-1:0]     r_base;
    logic [PN_W:0]       r_emit_cnt;
    logic [FP_SIZE-1:0]  r_pay_cnt;
    logic                r_out_val, r_done;
    logic [PN_W-1:0]     r_patch_num;
    logic [FP_SIZE-1:0]  r_payload;

    logic                w_start, w_clear, w_load, w_accept;
    logic                w_win_end, w_cand_ok, w_last;
    logic [K-1:0]        w_low, w_lfsr_next;
    logic [PN_W-1:0]     w_cand;

    assign w_win_end   = (r_off == '1);
    assign w_lfsr_next = {r_lfsr[K-2:0], ~^(r_lfsr & TAPS)};
    assign w_accept    = r_out_val && out_rdy;
    assign w_last      = (r_emit_cnt == LAST_IDX);

    // The LFSR never reaches all-ones, so that value fills the last slot of each window
    always_comb begin
        w_low = r_off;
        if (r_mode == 2'd1)
            w_low = w_win_end ? '1 : r_lfsr;
        else if (r_mode == 2'd2)
            w_low = ~r_off;
    end

    assign w_cand    = r_base + {{(PN_W-K){1'b0}}, w_low};
    assign w_cand_ok = ({1'b0, w_cand} < N_VAL);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_LOAD;
            S_LOAD:  w_state_next = S_RUN;
            S_RUN:   if (w_load && w_cand_ok && w_last) w_state_next = S_DRAIN;
            S_DRAIN: if (out_rdy) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = (r_state != S_IDLE);
        w_start = (r_state == S_IDLE) && start;
        w_clear = (r_state == S_LOAD);
        w_load  = (r_state == S_RUN) && (!r_out_val || out_rdy);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_mode      <= '0;
            r_off       <= '0;
            r_lfsr      <= '0;
            r_base      <= '0;
            r_emit_cnt  <= '0;
            r_pay_cnt   <= '0;
            r_out_val   <= 1'b0;
            r_patch_num <= '0;
            r_payload   <= '0;
            r_done      <= 1'b0;
        end else begin
            if (w_start) begin
                r_mode <= mode;
                r_done <= 1'b0;
            end else if (r_state == S_DRAIN && out_rdy) begin
                r_done <= 1'b1;
            end
            if (w_clear) begin
                r_off      <= '0;
                r_lfsr     <= '0;
                r_base     <= '0;
                r_emit_cnt <= '0;
                r_pay_cnt  <= '0;
                r_out_val  <= 1'b0;
            end else if (w_load) begin
                // Out-of-range candidates leave a bubble and consume no payload index
                r_out_val <= w_cand_ok;
                if (w_cand_ok) begin
                    r_patch_num <= w_cand;
                    r_payload   <= r_pay_cnt;
                    r_pay_cnt   <= r_pay_cnt + FP_SIZE'(1);
                    r_emit_cnt  <= r_emit_cnt + (PN_W+1)'(1);
                end
                r_off <= r_off + K'(1);
                if (w_win_end) begin
                    r_base <= r_base + WIN_STEP;
                    r_lfsr <= '0;
                end else begin
                    r_lfsr <= w_lfsr_next;
                end
            end else if (w_accept) begin
                r_out_val <= 1'b0;
            end
        end
    end

    assign out_val   = r_out_val;
    assign patch_num = r_patch_num;
    assign payload   = r_payload;
    assign done      = r_done;

`ifdef PATCH_STIM_CHECKSUM_EN
    logic [31:0] r_checksum;
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            r_checksum <= '0;
        else if (w_clear)
            r_checksum <= '0;
        else if (w_accept)
            r_checksum <= r_checksum + 32'(r_patch_num);
    end
    assign checksum = r_checksum;
`endif

endmodule

// File: tb/tb_patch_stim_gen.sv
// Directed bench for patch_stim_gen: three small instances (N=64, 40, 32; window 16) checked against a set/arith model.
module tb_patch_stim_gen;

    localparam int W = 16;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        st  [3];
    logic        rdy [3];
    logic [1:0]  md  [3];
    logic        val [3];
    logic        bsy [3];
    logic        dn  [3];
    logic [19:0] pl  [3];
    logic [5:0]  pn0, pn1;
    logic [4:0]  pn2;
`ifdef PATCH_STIM_CHECKSUM_EN
    logic [31:0] cs  [3];
`endif

    int vectors     = 0;
    int miscompares = 0;

    bit active   [3];
    int run_mode [3];
    int acc      [3];
    bit hold     [3];
    int hpn      [3];
    int hpl      [3];
    int first_pn [3];
    int val_cyc  [3];
    int gaps     [3];
    bit seen     [3][64];

    always #5 CLK = ~CLK;

    patch_stim_gen #(.N_PATCH(64), .SYNC_WINDOW_LOG2(4), .FP_SIZE(20)) u0 (
        .CLK(CLK), .RESET(RESET), .start(st[0]), .mode(md[0]), .out_val(val[0]),
        .out_rdy(rdy[0]), .patch_num(pn0), .payload(pl[0]), .busy(bsy[0]), .done(dn[0])
`ifdef PATCH_STIM_CHECKSUM_EN
        , .checksum(cs[0])
`endif
    );
    patch_stim_gen #(.N_PATCH(40), .SYNC_WINDOW_LOG2(4), .FP_SIZE(20)) u1 (
        .CLK(CLK), .RESET(RESET), .start(st[1]), .mode(md[1]), .out_val(val[1]),
        .out_rdy(rdy[1]), .patch_num(pn1), .payload(pl[1]), .busy(bsy[1]), .done(dn[1])
`ifdef PATCH_STIM_CHECKSUM_EN
        , .checksum(cs[1])
`endif
    );
    patch_stim_gen #(.N_PATCH(32), .SYNC_WINDOW_LOG2(4), .FP_SIZE(20)) u2 (
        .CLK(CLK), .RESET(RESET), .start(st[2]), .mode(md[2]), .out_val(val[2]),
        .out_rdy(rdy[2]), .patch_num(pn2), .payload(pl[2]), .busy(bsy[2]), .done(dn[2])
`ifdef PATCH_STIM_CHECKSUM_EN
        , .checksum(cs[2])
`endif
    );

    function automatic int np(input int i);
        case (i)
            0:       return 64;
            1:       return 40;
            default: return 32;
        endcase
    endfunction

    function automatic int get_pn(input int i);
        case (i)
            0:       return int'(pn0);
            1:       return int'(pn1);
            default: return int'(pn2);
        endcase
    endfunction

    // idx-th emitted value when every window of W is walked top-down, skipping values >= n
    function automatic int reversed_nth(input int n, input int idx);
        int k = 0;
        for (int b = 0; b < n; b += W)
            for (int j = W - 1; j >= 0; j--)
                if (b + j < n) begin
                    if (k == idx) return b + j;
                    k++;
                end
        return -1;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Per-cycle compare against the model, sampled mid-cycle
    always @(negedge CLK) begin
        for (int i = 0; i < 3; i++) begin
            if (active[i]) begin
                int p;
                p = get_pn(i);
                check($sformatf("done_u%0d_acc%0d", i, acc[i]), dn[i], (acc[i] == np(i)) ? 1 : 0);
                if (hold[i]) begin
                    check($sformatf("stall_val_u%0d", i), val[i], 1);
                    check($sformatf("stall_pn_u%0d", i), p, hpn[i]);
                    check($sformatf("stall_pl_u%0d", i), pl[i], hpl[i]);
                end
                if (val[i]) begin
                    if (first_pn[i] < 0) first_pn[i] = p;
                    val_cyc[i]++;
                end else if (bsy[i] && first_pn[i] >= 0) begin
                    gaps[i]++;
                end
                if (val[i] && rdy[i]) begin
                    check($sformatf("payload_u%0d_w%0d", i, acc[i]), pl[i], acc[i]);
                    if (run_mode[i] == 1) begin
                        check($sformatf("window_u%0d_w%0d", i, acc[i]), p / W, acc[i] / W);
                        check($sformatf("inrange_u%0d_w%0d", i, acc[i]), (p < np(i)) ? 1 : 0, 1);
                        check($sformatf("unique_u%0d_pn%0d", i, p), seen[i][p], 0);
                        if (acc[i] % W == W - 1)
                            check($sformatf("lastlow_u%0d_w%0d", i, acc[i]), p % W, W - 1);
                        seen[i][p] = 1'b1;
                    end else if (run_mode[i] == 2) begin
                        check($sformatf("rev_pn_u%0d_w%0d", i, acc[i]), p, reversed_nth(np(i), acc[i]));
                    end else begin
                        check($sformatf("seq_pn_u%0d_w%0d", i, acc[i]), p, acc[i]);
                    end
                    acc[i]++;
                end
                hold[i] = val[i] && !rdy[i];
                hpn[i]  = p;
                hpl[i]  = int'(pl[i]);
            end
        end
    end

    task automatic run(input int i, input int m, input bit stall, input int rst_at);
        int  cyc;
        int  nseen;
        bit  aborted;
        md[i]       = 2'(m);
        run_mode[i] = m;
        acc[i]      = 0;
        hold[i]     = 1'b0;
        first_pn[i] = -1;
        val_cyc[i]  = 0;
        gaps[i]     = 0;
        for (int v = 0; v < 64; v++) seen[i][v] = 1'b0;
        st[i] = 1'b1;
        @(posedge CLK); #1;
        st[i]     = 1'b0;
        active[i] = 1'b1;
        check($sformatf("load_busy_u%0d", i), bsy[i], 1);
        check($sformatf("load_val_u%0d", i), val[i], 0);
        check($sformatf("load_done_u%0d", i), dn[i], 0);
        @(posedge CLK); #1;
        check($sformatf("lat1_val_u%0d", i), val[i], 0);
        @(posedge CLK); #1;
        check($sformatf("lat2_val_u%0d", i), val[i], 1);
        cyc     = 0;
        aborted = 1'b0;
        while (!dn[i] && cyc < 400 && !aborted) begin
            rdy[i] = !(stall && cyc >= 5 && cyc <= 9);
            if (rst_at >= 0 && acc[i] >= rst_at) begin
                #1 RESET = 1'b0;
                active[i] = 1'b0;
                #1;
                check($sformatf("arst_val_u%0d", i), val[i], 0);
                check($sformatf("arst_pn_u%0d", i), get_pn(i), 0);
                check($sformatf("arst_pl_u%0d", i), pl[i], 0);
                check($sformatf("arst_busy_u%0d", i), bsy[i], 0);
                check($sformatf("arst_done_u%0d", i), dn[i], 0);
                @(posedge CLK); #1;
                RESET = 1'b1;
                @(posedge CLK); #1;
                check($sformatf("post_rst_busy_u%0d", i), bsy[i], 0);
                aborted = 1'b1;
            end else begin
                @(posedge CLK); #1;
                cyc++;
            end
        end
        rdy[i] = 1'b1;
        if (!aborted) begin
            check($sformatf("run_complete_u%0d_m%0d", i, m), dn[i], 1);
            check($sformatf("accepts_u%0d_m%0d", i, m), acc[i], np(i));
            check($sformatf("end_busy_u%0d", i), bsy[i], 0);
            check($sformatf("end_val_u%0d", i), val[i], 0);
            if (m == 1) begin
                nseen = 0;
                for (int v = 0; v < 64; v++) nseen += int'(seen[i][v]);
                check($sformatf("perm_count_u%0d", i), nseen, np(i));
            end
`ifdef PATCH_STIM_CHECKSUM_EN
            check($sformatf("checksum_u%0d", i), cs[i], (np(i) * (np(i) - 1)) / 2);
`endif
            @(negedge CLK);
            active[i] = 1'b0;
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        RESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            st[i] = 1'b0; rdy[i] = 1'b1; md[i] = 2'd0; active[i] = 1'b0;
        end
        repeat (3) @(posedge CLK);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_val_u%0d", i), val[i], 0);
            check($sformatf("rst_pn_u%0d", i), get_pn(i), 0);
            check($sformatf("rst_pl_u%0d", i), pl[i], 0);
            check($sformatf("rst_busy_u%0d", i), bsy[i], 0);
            check($sformatf("rst_done_u%0d", i), dn[i], 0);
        end
        RESET = 1'b1;
        @(posedge CLK); #1;

        run(0, 0, 1'b0, -1);
        check("seq_first_pn", first_pn[0], 0);
        check("seq_val_cycles", val_cyc[0], 64);
        check("seq_gaps", gaps[0], 0);

        run(0, 1, 1'b0, -1);
        check("shuf_first_pn", first_pn[0], 0);
        check("shuf_full_gaps", gaps[0], 0);

        run(1, 1, 1'b0, -1);
        check("shuf_partial_gaps_seen", (gaps[1] > 0 && gaps[1] <= 8) ? 1 : 0, 1);
        check("shuf_partial_val_cycles", val_cyc[1], 40);

        run(2, 2, 1'b1, -1);
        check("rev_first_pn", first_pn[2], 15);
        check("rev_val_cycles_with_stall", val_cyc[2], 37);

        run(0, 0, 1'b0, 20);
        run(0, 0, 1'b0, -1);
        check("rerun_first_pn", first_pn[0], 0);
        check("rerun_val_cycles", val_cyc[0], 64);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
